// File: rtl/multsigned_pkg.sv
// Shared definitions for the signed partial-product datapath: FSM states and
// width helpers so producer and consumer derive identical sizes.
package multsigned_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Radix-8 style grouping: one partial product per 3 multiplier bits.
  function automatic int pp_per_mul_f(input int in_size_1);
    return (in_size_1 + 2) / 3;
  endfunction

  // Accumulator must hold MAX_LEN products without overflow.
  function automatic int acc_size_f(input int pp_size, input int max_len);
    return pp_size + $clog2(max_len);
  endfunction

endpackage

// File: rtl/pp_lane_reducer.sv
// One lane: reduces its partial products to a signed product (stage 1),
// then accumulates the registered product into a wide signed sum.
module pp_lane_reducer
  import multsigned_pkg::*;
#(
  parameter int PP_PER_MUL = 3,
  parameter int PP_SIZE    = 12,
  parameter int ACC_SIZE   = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PP_SIZE-1:0]  pp [0:PP_PER_MUL-1],
  input  logic                enable,
  input  logic                clear,
  output logic [ACC_SIZE-1:0] acc
);

  logic [PP_SIZE-1:0] sum;
  logic [PP_SIZE-1:0] product_q;
  logic               valid_q;

  // Sum the partial products modulo 2^PP_SIZE; the result is the two's
  // complement product.
  always_comb begin
    sum = '0;
    for (int j = 0; j < PP_PER_MUL; j++) begin
      sum = sum + pp[j];
    end
  end

  // Stage-1 product register with its valid bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      product_q <= '0;
      valid_q   <= 1'b0;
    end else if (clear) begin
      valid_q   <= 1'b0;
    end else begin
      valid_q <= enable;
      if (enable) begin
        product_q <= sum;
      end
    end
  end

  // Accumulate the sign-extended product; wraps modulo 2^ACC_SIZE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (valid_q) begin
      acc <= acc + {{(ACC_SIZE-PP_SIZE){product_q[PP_SIZE-1]}}, product_q};
    end
  end

endmodule

// File: rtl/pp_accumulator_array.sv
// Consumer of the partial-product interface: per-lane reduce and accumulate
// over a programmed number of beats, results offered with valid/ready.
module pp_accumulator_array
  import multsigned_pkg::*;
#(
  parameter int IN_SIZE_0    = 4,
  parameter int IN_SIZE_1    = 8,
  parameter int ARRAY_SIZE   = 8,
  parameter int MAX_LEN      = 256,
  parameter int PP_PER_MUL   = pp_per_mul_f(IN_SIZE_1),
  parameter int PP_PER_ARRAY = PP_PER_MUL * ARRAY_SIZE,
  parameter int PP_SIZE      = IN_SIZE_0 + IN_SIZE_1,
  parameter int LEN_SIZE     = $clog2(MAX_LEN + 1),
  parameter int ACC_SIZE     = acc_size_f(PP_SIZE, MAX_LEN)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [LEN_SIZE-1:0] len_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [PP_SIZE-1:0]  pp_i [0:PP_PER_ARRAY-1],
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [ACC_SIZE-1:0] acc_o [0:ARRAY_SIZE-1],
  output logic                busy_o
);

  state_t              state;
  state_t              next_state;
  logic [LEN_SIZE-1:0] count;
  logic                accept;
  logic                start_ok;
  logic                last_beat;

  assign accept    = in_valid_i && in_ready_o && (state == ACCUM);
  assign start_ok  = (state == IDLE) && start_i && (len_i != '0) &&
                     (len_i <= LEN_SIZE'(MAX_LEN));
  assign last_beat = accept && (count == LEN_SIZE'(1));

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_ok)    next_state = ACCUM;
      ACCUM:   if (last_beat)   next_state = FLUSH;
      FLUSH:                    next_state = DONE;
      DONE:    if (out_ready_i) next_state = IDLE;
      default:                  next_state = IDLE;
    endcase
  end

  // State register plus handshake outputs registered from the next state,
  // so they never depend combinationally on the inputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      in_ready_o  <= 1'b0;
      out_valid_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      state       <= next_state;
      in_ready_o  <= (next_state == ACCUM);
      out_valid_o <= (next_state == DONE);
      busy_o      <= (next_state != IDLE);
    end
  end

  // Remaining-beat counter: loaded on a valid start, decremented per beat.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count <= '0;
    end else if (start_ok) begin
      count <= len_i;
    end else if (accept) begin
      count <= count - LEN_SIZE'(1);
    end
  end

  // One reducer/accumulator per lane, fed its own slice of the beat.
  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
    logic [PP_SIZE-1:0] lane_pp [0:PP_PER_MUL-1];

    for (genvar j = 0; j < PP_PER_MUL; j++) begin : g_pp
      assign lane_pp[j] = pp_i[i*PP_PER_MUL + j];
    end

    pp_lane_reducer #(
      .PP_PER_MUL (PP_PER_MUL),
      .PP_SIZE    (PP_SIZE),
      .ACC_SIZE   (ACC_SIZE)
    ) u_lane (
      .clk    (clk_i),
      .rst    (rst_i),
      .pp     (lane_pp),
      .enable (accept),
      .clear  (start_ok),
      .acc    (acc_o[i])
    );
  end

endmodule
